// File: rtl/rc4_stream_engine.sv
// RC4 keystream engine: fills an external 256x8 S memory, runs the key schedule, then
// streams MSG_LEN PRGA keystream bytes over valid/ready. S memory q lags address by one cycle.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | s[i] = i, one write per cycle
// P_INC  | PRGA: advance i
// RD_I   | present address i
// WT_I   | s[i] in flight
// CAP_I  | capture si, update j, present new j
// WT_J   | s[j] in flight
// WR_I   | capture sj, write s[i] = sj
// WR_J   | write s[j] = si (KSA: advance i, k)
// WT_K   | PRGA: present si+sj
// EMIT   | PRGA: capture keystream byte
// HOLD   | keystream byte offered until accepted
// DONE   | one-cycle completion pulse
module rc4_stream_engine #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             phase,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_wren,
    input  logic [7:0]             mem_rdata,
    output logic                   ks_valid,
    output logic [7:0]             ks_data,
    input  logic                   ks_ready,
    output logic                   ks_last
);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(KEY_BYTES - 1);
    localparam logic [7:0]    CNT_LAST = 8'(MSG_LEN - 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_INIT  = 4'd1;
    localparam logic [3:0] S_P_INC = 4'd2;
    localparam logic [3:0] S_RD_I  = 4'd3;
    localparam logic [3:0] S_WT_I  = 4'd4;
    localparam logic [3:0] S_CAP_I = 4'd5;
    localparam logic [3:0] S_WT_J  = 4'd6;
    localparam logic [3:0] S_WR_I  = 4'd7;
    localparam logic [3:0] S_WR_J  = 4'd8;
    localparam logic [3:0] S_WT_K  = 4'd9;
    localparam logic [3:0] S_EMIT  = 4'd10;
    localparam logic [3:0] S_HOLD  = 4'd11;
    localparam logic [3:0] S_DONE  = 4'd12;

    logic [3:0]             state;
    logic [7:0]             i;
    logic [7:0]             j;
    logic [7:0]             si;
    logic [7:0]             sj;
    logic [KW-1:0]          k;
    logic [7:0]             count;
    logic                   in_prga;
    logic [8*KEY_BYTES-1:0] key_reg;
    logic [7:0]             ks_data_r;
    logic                   ks_last_r;

    logic [7:0] key_arr [KEY_BYTES];
    logic [7:0] key_byte;
    logic [7:0] j_cap;

    // Byte 0 of the key sits in the most significant byte lane.
    for (genvar b = 0; b < KEY_BYTES; b++) begin : g_key
        assign key_arr[b] = key_reg[8*(KEY_BYTES-1-b) +: 8];
    end

    assign key_byte = key_arr[k];
    assign j_cap    = j + mem_rdata + (in_prga ? 8'd0 : key_byte);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            i         <= 8'd0;
            j         <= 8'd0;
            si        <= 8'd0;
            sj        <= 8'd0;
            k         <= '0;
            count     <= 8'd0;
            in_prga   <= 1'b0;
            key_reg   <= '0;
            ks_data_r <= 8'd0;
            ks_last_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_reg <= key;
                        i       <= 8'd0;
                        in_prga <= 1'b0;
                        state   <= S_INIT;
                    end
                end
                S_INIT: begin
                    i <= i + 8'd1;
                    if (i == 8'hFF) begin
                        j     <= 8'd0;
                        k     <= '0;
                        state <= S_RD_I;
                    end
                end
                S_P_INC: begin
                    i     <= i + 8'd1;
                    state <= S_RD_I;
                end
                S_RD_I: state <= S_WT_I;
                S_WT_I: state <= S_CAP_I;
                S_CAP_I: begin
                    si    <= mem_rdata;
                    j     <= j_cap;
                    state <= S_WT_J;
                end
                S_WT_J: state <= S_WR_I;
                S_WR_I: begin
                    sj    <= mem_rdata;
                    state <= S_WR_J;
                end
                S_WR_J: begin
                    if (in_prga) begin
                        state <= S_WT_K;
                    end else begin
                        i <= i + 8'd1;
                        k <= (k == K_LAST) ? '0 : k + KW'(1);
                        // i wraps to 0 here, which is exactly the PRGA starting index
                        if (i == 8'hFF) begin
                            in_prga <= 1'b1;
                            j       <= 8'd0;
                            count   <= 8'd0;
                            state   <= S_P_INC;
                        end else begin
                            state <= S_RD_I;
                        end
                    end
                end
                S_WT_K: state <= S_EMIT;
                S_EMIT: begin
                    ks_data_r <= mem_rdata;
                    ks_last_r <= (count == CNT_LAST);
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (ks_ready) begin
                        count     <= count + 8'd1;
                        ks_last_r <= 1'b0;
                        state     <= ks_last_r ? S_DONE : S_P_INC;
                    end
                end
                S_DONE: begin
                    in_prga <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // CAP_I presents the freshly computed j so the S memory read starts immediately.
    always_comb begin
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        mem_wren  = 1'b0;
        case (state)
            S_INIT: begin
                mem_addr  = i;
                mem_wdata = i;
                mem_wren  = 1'b1;
            end
            S_RD_I, S_WT_I: mem_addr = i;
            S_CAP_I:        mem_addr = j_cap;
            S_WT_J:         mem_addr = j;
            S_WR_I: begin
                mem_addr  = i;
                mem_wdata = mem_rdata;
                mem_wren  = 1'b1;
            end
            S_WR_J: begin
                mem_addr  = j;
                mem_wdata = si;
                mem_wren  = 1'b1;
            end
            S_WT_K:         mem_addr = si + sj;
            default: ;
        endcase
    end

    always_comb begin
        phase = 2'd0;
        case (state)
            S_IDLE, S_DONE: phase = 2'd0;
            S_INIT:         phase = 2'd1;
            default:        phase = in_prga ? 2'd3 : 2'd2;
        endcase
    end

    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);
    assign ks_valid = (state == S_HOLD);
    assign ks_data  = ks_data_r;
    assign ks_last  = ks_last_r;

endmodule
